// File: rtl/nec_ir_rx_pkg.sv
// Shared types for the NEC IR receiver: FSM states, pulse windows in ticks, FIFO frame word.
package nec_ir_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_RPT_STOP
  } state_t;

  localparam int LEAD_MARK_MIN  = 96;
  localparam int LEAD_MARK_MAX  = 160;
  localparam int LEAD_SPACE_MIN = 48;
  localparam int LEAD_SPACE_MAX = 80;
  localparam int RPT_SPACE_MIN  = 24;
  localparam int RPT_SPACE_MAX  = 40;
  localparam int BIT_MARK_MIN   = 4;
  localparam int BIT_MARK_MAX   = 12;
  localparam int SPACE0_MIN     = 4;
  localparam int SPACE0_MAX     = 12;
  localparam int SPACE1_MIN     = 18;
  localparam int SPACE1_MAX     = 30;

  typedef struct packed {
    logic        rpt;
    logic        ext;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } frame_t;

  function automatic logic in_win(input int d, input int lo, input int hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_rx_fifo.sv
// Synchronous show-ahead FIFO; head is presented on dout, forced to zero while empty.
module nec_ir_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int FW    = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [FW-1:0] din,
  input  logic          pop,
  output logic [FW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same clock, so a full FIFO still accepts a push then.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nec_ir_rx_ext.sv
// NEC / extended-NEC IR receiver: synchroniser, 2-sample glitch filter, pulse timer, frame FSM, frame FIFO.
// Define NEC_IR_RX_ERR_CNT_EN to add the saturating err_cnt output.
module nec_ir_rx_ext
  import nec_ir_rx_pkg::*;
#(
  parameter int NB_STAGES = 3,
  parameter int TSIZE     = 8,
  parameter int DEPTH     = 4,
  parameter int FW        = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ir_rx,
  input  logic          tick,
  input  logic          cfg_en,
  input  logic          cfg_polarity,
  input  logic          cfg_repeat_en,
  input  logic          cfg_ext_addr,
  input  logic          rd_en,
  output logic [FW-1:0] rd_data,
  output logic          rd_empty,
  output logic          fifo_full,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          frame_err
`ifdef NEC_IR_RX_ERR_CNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  localparam logic [TSIZE-1:0] TMAX = '1;

  logic [NB_STAGES-1:0] sync_q;
  logic                 mark_s, samp_q, level, edge_det;
  logic [TSIZE-1:0]     dur, dur_inc;
  int                   dur_int;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg;
  logic [7:0]  b0, b1, b2, b3;
  logic [15:0] rx_addr;
  logic        frame_ok, bm_ok, sp0_ok, sp1_ok, drop;
  frame_t      last_q, push_word;
  logic        last_valid, push_v;

  assign mark_s   = cfg_polarity ? sync_q[NB_STAGES-1] : ~sync_q[NB_STAGES-1];
  assign edge_det = tick && (mark_s == samp_q) && (mark_s != level);
  assign dur_inc  = (dur == TMAX) ? dur : dur + TSIZE'(1);
  assign dur_int  = 32'(dur_inc);

  assign {b3, b2, b1, b0} = shreg;
  assign frame_ok = (b2 == ~b3) && (cfg_ext_addr || (b0 == ~b1));
  assign rx_addr  = cfg_ext_addr ? {b1, b0} : {8'h00, b0};
  assign bm_ok    = in_win(dur_int, BIT_MARK_MIN, BIT_MARK_MAX);
  assign sp0_ok   = in_win(dur_int, SPACE0_MIN, SPACE0_MAX);
  assign sp1_ok   = in_win(dur_int, SPACE1_MIN, SPACE1_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      samp_q <= 1'b0;
      level  <= 1'b0;
      dur    <= '0;
    end else begin
      sync_q <= {sync_q[NB_STAGES-2:0], ir_rx};
      if (!cfg_en) begin
        samp_q <= 1'b0;
        level  <= 1'b0;
        dur    <= '0;
      end else if (tick) begin
        samp_q <= mark_s;
        if (edge_det) begin
          level <= mark_s;
          dur   <= '0;
        end else begin
          dur <= dur_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      last_q     <= '0;
      last_valid <= 1'b0;
      push_v     <= 1'b0;
      push_word  <= '0;
      frame_err  <= 1'b0;
    end else begin
      push_v    <= 1'b0;
      frame_err <= 1'b0;
      if (!cfg_en) begin
        state      <= S_IDLE;
        last_valid <= 1'b0;
      end else if (edge_det) begin
        // Unless a branch below accepts the edge, the frame is rejected.
        state     <= S_IDLE;
        frame_err <= (state != S_IDLE);
        case (state)
          S_IDLE: if (mark_s) state <= S_LEAD_MARK;
          S_LEAD_MARK:
            if (in_win(dur_int, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
              state     <= S_LEAD_SPACE;
              frame_err <= 1'b0;
            end
          S_LEAD_SPACE:
            if (in_win(dur_int, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
              state     <= S_BIT_MARK;
              bit_cnt   <= '0;
              frame_err <= 1'b0;
            end else if (in_win(dur_int, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
              state     <= S_RPT_STOP;
              frame_err <= 1'b0;
            end
          S_BIT_MARK:
            if (bm_ok) begin
              state     <= S_BIT_SPACE;
              frame_err <= 1'b0;
            end
          S_BIT_SPACE:
            if (sp0_ok || sp1_ok) begin
              shreg     <= {sp1_ok, shreg[31:1]};
              bit_cnt   <= bit_cnt + 5'd1;
              state     <= (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
              frame_err <= 1'b0;
            end
          S_STOP_MARK:
            if (bm_ok) begin
              if (frame_ok) begin
                push_v     <= 1'b1;
                push_word  <= {1'b0, cfg_ext_addr, rx_addr, b2};
                last_q     <= {1'b0, cfg_ext_addr, rx_addr, b2};
                last_valid <= 1'b1;
                frame_err  <= 1'b0;
              end else begin
                last_valid <= 1'b0;
              end
            end
          S_RPT_STOP:
            if (bm_ok) begin
              frame_err <= 1'b0;
              if (cfg_repeat_en && last_valid) begin
                push_v    <= 1'b1;
                push_word <= {1'b1, last_q.ext, last_q.addr, last_q.cmd};
              end
            end
          default: ;
        endcase
      end else if (tick && (dur_inc == TMAX) && (state != S_IDLE)) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  nec_ir_rx_fifo #(.DEPTH(DEPTH), .FW(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_v),
    .din   (push_word),
    .pop   (rd_en),
    .dout  (rd_data),
    .empty (rd_empty),
    .full  (fifo_full)
  );

  assign drop = push_v && fifo_full && !rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      if (ovf_clr) ovf <= 1'b0;
      if (drop)    ovf <= 1'b1;
    end
  end

`ifdef NEC_IR_RX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) err_cnt <= '0;
    else if (frame_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_nec_ir_rx_ext.sv
// Directed bench for nec_ir_rx_ext: frames built tick by tick, expected FIFO words computed by hand.
module tb_nec_ir_rx_ext;

  logic        clk = 1'b0;
  logic        rst, ir_rx, tick, cfg_en, cfg_polarity, cfg_repeat_en, cfg_ext_addr;
  logic        rd_en, ovf_clr;
  logic [25:0] rd_data;
  logic        rd_empty, fifo_full, ovf, frame_err;
`ifdef NEC_IR_RX_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  nec_ir_rx_ext dut (
    .clk           (clk),
    .rst           (rst),
    .ir_rx         (ir_rx),
    .tick          (tick),
    .cfg_en        (cfg_en),
    .cfg_polarity  (cfg_polarity),
    .cfg_repeat_en (cfg_repeat_en),
    .cfg_ext_addr  (cfg_ext_addr),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_empty      (rd_empty),
    .fifo_full     (fifo_full),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr),
    .frame_err     (frame_err)
`ifdef NEC_IR_RX_ERR_CNT_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  always @(negedge clk) if (frame_err) err_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One tick strobe every 4 clocks; optional rd_en on the clock after the strobe.
  task automatic do_tick(input bit pop_after);
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    if (pop_after) begin
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
    end
  endtask

  task automatic send(input bit mark, input int n);
    ir_rx = mark ? 1'b0 : 1'b1;
    repeat (n) do_tick(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                            input logic [7:0] c3, input int lead, input int glitch_bit,
                            input int abort_bit, input bit pop_end);
    logic [31:0] w;
    w = {c3, c2, c1, c0};
    send(1'b1, lead);
    send(1'b0, 64);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_bit) begin
        cfg_en = 1'b0;
        send(1'b0, 20);
        cfg_en = 1'b1;
        send(1'b0, 10);
        return;
      end
      send(1'b1, 8);
      if (w[i]) begin
        if (i == glitch_bit) begin
          send(1'b0, 10);
          send(1'b1, 1);
          send(1'b0, 13);
        end else begin
          send(1'b0, 24);
        end
      end else begin
        send(1'b0, 8);
      end
    end
    send(1'b1, 8);
    ir_rx = 1'b1;
    do_tick(1'b0);
    do_tick(pop_end);
    send(1'b0, 20);
  endtask

  task automatic send_repeat();
    send(1'b1, 128);
    send(1'b0, 32);
    send(1'b1, 8);
    send(1'b0, 20);
  endtask

  task automatic pop();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  logic [7:0] k8;

  initial begin
    rst = 1'b1; ir_rx = 1'b1; tick = 1'b0; cfg_en = 1'b1; cfg_polarity = 1'b0;
    cfg_repeat_en = 1'b0; cfg_ext_addr = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_empty", rd_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b0;
    send(1'b0, 10);

    // standard frame
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 128, -1, -1, 1'b0);
    chk("std_empty", rd_empty, 0);
    chk("std_data", rd_data, 26'h005A3C);
    chk("std_noerr", err_seen, 0);
    pop();
    chk("std_popped", rd_empty, 1);

    // extended address, then same bytes rejected in standard mode
    cfg_ext_addr = 1'b1;
    send_frame(8'h34, 8'h12, 8'hC8, 8'h37, 128, -1, -1, 1'b0);
    chk("ext_data", rd_data, 26'h11234C8);
    pop();
    cfg_ext_addr = 1'b0;
    send_frame(8'h34, 8'h12, 8'hC8, 8'h37, 128, -1, -1, 1'b0);
    chk("ext_in_std_err", err_seen, 1);
    chk("ext_in_std_empty", rd_empty, 1);

    // repeat codes
    cfg_repeat_en = 1'b1;
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 128, -1, -1, 1'b0);
    send_repeat();
    chk("rpt_first", rd_data, 26'h005A3C);
    pop();
    chk("rpt_second", rd_data, 26'h2005A3C);
    pop();
    chk("rpt_drained", rd_empty, 1);
    cfg_repeat_en = 1'b0;
    send_repeat();
    chk("rpt_off_empty", rd_empty, 1);
    chk("rpt_off_noerr", err_seen, 1);

    // leader window edges and glitch rejection
    send(1'b1, 95);
    send(1'b0, 40);
    chk("lead95_err", err_seen, 2);
    chk("lead95_empty", rd_empty, 1);
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 160, 3, -1, 1'b0);
    chk("lead160_data", rd_data, 26'h005A3C);
    chk("lead160_noerr", err_seen, 2);
    pop();

    // overflow
    for (int k = 1; k <= 5; k++) begin
      k8 = 8'(k);
      send_frame(8'h5A, 8'hA5, k8, ~k8, 128, -1, -1, 1'b0);
    end
    chk("ovf_full", fifo_full, 1);
    chk("ovf_set", ovf, 1);
    chk("ovf_head", rd_data, 26'h005A01);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    k8 = 8'h06;
    send_frame(8'h5A, 8'hA5, k8, ~k8, 128, -1, -1, 1'b1);
    chk("pushpop_full", fifo_full, 1);
    chk("pushpop_noovf", ovf, 0);
    chk("drain0", rd_data, 26'h005A02);
    pop();
    chk("drain1", rd_data, 26'h005A03);
    pop();
    chk("drain2", rd_data, 26'h005A04);
    pop();
    chk("drain3", rd_data, 26'h005A06);
    pop();
    chk("drain_empty", rd_empty, 1);
    chk("drain_notfull", fifo_full, 0);

    // enable dropped mid-frame
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 128, -1, 17, 1'b0);
    chk("abort_empty", rd_empty, 1);
    chk("abort_noerr", err_seen, 2);
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 128, -1, -1, 1'b0);
    chk("after_abort_data", rd_data, 26'h005A3C);
    chk("after_abort_noerr", err_seen, 2);
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
